accelerator_vector_logarithm_function: RTL
==========================================

# accelerator_vector_logarithm_function

Vector sequencer that computes the natural logarithm of every element of an IEEE-754 floating-point vector. It streams elements one at a time into an internal `accelerator_scalar_logarithm_function` instance and returns results in input order. It sits directly upstream of that scalar unit and feeds it. NTM vector datapaths use it wherever an element-wise `ln` is needed.

## Interface
- DATA_SIZE, 64: element width in bits; IEEE-754 format matching the scalar float units.
- CONTROL_SIZE, 4: forwarded unchanged to the scalar logarithm instance.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- START  in  1  begin a vector operation; sampled only in STARTER_STATE.
- READY  out  1  one-cycle pulse when the whole vector is done.
- SIZE_IN  in  DATA_SIZE  element count; latched on accepted START.
- DATA_IN_ENABLE  in  1  upstream asserts when DATA_IN holds the requested element.
- DATA_ENABLE  out  1  request for the next input element.
- DATA_IN  in  DATA_SIZE  input element.
- DATA_OUT  out  DATA_SIZE  ln of the current element.
- DATA_OUT_ENABLE  out  1  one-cycle strobe; DATA_OUT is valid in that cycle.

## Operation
- Reset: state = STARTER_STATE. READY = 0, DATA_ENABLE = 0, DATA_OUT_ENABLE = 0, DATA_OUT = 0. Index counter = 0, latched size = 0, scalar START = 0. The scalar instance is reset by the same RST.
- Index counter and latched size are DATA_SIZE wide. Index compares against latched size − 1. Wrap-around cannot occur.
- STARTER_STATE:
  - READY and DATA_OUT_ENABLE are driven 0.
  - START = 1 and SIZE_IN = 0: READY = 1 for one cycle. No DATA_ENABLE or DATA_OUT_ENABLE. Stay in STARTER_STATE.
  - START = 1 and SIZE_IN > 0: latch SIZE_IN, index = 0, DATA_ENABLE = 1, go to INPUT_STATE.
- INPUT_STATE:
  - DATA_IN_ENABLE = 0: hold DATA_ENABLE = 1 and wait indefinitely.
  - DATA_IN_ENABLE = 1: register DATA_IN into the scalar DATA_IN, pulse scalar START for exactly one cycle, DATA_ENABLE = 0, go to ENDER_STATE.
- ENDER_STATE:
  - Wait for the scalar READY.
  - In the cycle after scalar READY: DATA_OUT = scalar DATA_OUT, DATA_OUT_ENABLE = 1 for one cycle.
  - If index = latched size − 1: READY = 1 in that same cycle, index = 0, go to STARTER_STATE.
  - Otherwise: index + 1, DATA_ENABLE = 1, go to INPUT_STATE.
- DATA_OUT holds its last value between strobes and after READY.
- START is ignored outside STARTER_STATE. SIZE_IN changes after the accepted START have no effect.
- DATA_IN_ENABLE is ignored outside INPUT_STATE. Extra strobes are not queued.
- Special values (0, negative, NaN, Inf) pass through unchanged to the scalar unit. Their result is whatever the scalar unit produces; this block adds no checking.
- RST asserted mid-vector: immediate return to the reset state. The partial vector is abandoned, no READY is produced, and any in-flight scalar result is discarded.

## Timing
- START to first DATA_ENABLE: 1 cycle.
- DATA_IN_ENABLE to scalar START: 1 cycle.
- Per element, accept to DATA_OUT_ENABLE: L + 2 cycles, where L is the scalar latency (scalar START to scalar READY).
- DATA_OUT_ENABLE to next DATA_ENABLE: same edge; DATA_ENABLE rises in the strobe cycle.
- Vector latency with zero upstream stall: N·(L + 3) cycles.
- Last DATA_OUT_ENABLE and READY coincide in the same cycle.
- Back-to-back vectors: a new START is accepted the cycle after READY.
- Exactly one element is in flight at a time; no pipelining across elements.

## Test plan
- Reset mid-vector: SIZE_IN = 4, assert RST after element 2 has been accepted → all outputs are 0 in the same cycle. A following vector with SIZE_IN = 1 and DATA_IN = 0x3FF0000000000000 completes normally with DATA_OUT = 0.
- Single element: SIZE_IN = 1, DATA_IN = 0x3FF0000000000000 (1.0) → one DATA_ENABLE, one DATA_OUT_ENABLE with DATA_OUT = 0x0000000000000000, READY in the same cycle.
- Three elements: {1.0, e = 0x4005BF0A8B145769, e² = 0x401D8E64B8D4DDAE} with zero stall → outputs in order {0.0, 1.0, 2.0} within the scalar unit's tolerance. Three strobes spaced L + 3 cycles apart; READY with the third strobe.
- Upstream stall: hold DATA_IN_ENABLE low for 20 cycles on element 2 of SIZE_IN = 3 → DATA_ENABLE stays high throughout. Results unchanged; total latency grows by exactly 20 cycles.
- Empty vector and ignored START: SIZE_IN = 0 → READY one cycle after START with no DATA_ENABLE. During a SIZE_IN = 2 run, pulse START and change SIZE_IN to 5 → exactly 2 outputs are produced.

Source files
------------

// File: rtl/accelerator_vector_logarithm_function.sv
// Element-wise natural logarithm over a binary64 vector, one element in
// flight at a time, plus the iterative scalar logarithm unit it feeds.

module accelerator_scalar_logarithm_function #(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic                 READY,
    output logic [DATA_SIZE-1:0] DATA_OUT
);
    // ln(x) = (e + log2(m)) * ln2; log2(m) by repeated squaring, one bit per cycle
    localparam int unsigned FRAC_BITS  = 60;
    localparam int unsigned FIX_BITS   = 72;
    localparam int unsigned LEAD_BITS  = 7;
    localparam int unsigned ITER_BITS  = 6;
    localparam int unsigned EXP_OFFSET = 1023 - FRAC_BITS;
    localparam logic [63:0] LN2_Q64    = 64'hB17217F7D1CF79AB;
    localparam logic [63:0] QNAN       = 64'h7FF8000000000000;
    localparam logic [63:0] NEG_INF    = 64'hFFF0000000000000;
    localparam logic [63:0] POS_INF    = 64'h7FF0000000000000;

    typedef logic [CONTROL_SIZE-1:0] ctrl_t;
    localparam ctrl_t S_IDLE  = ctrl_t'(0);
    localparam ctrl_t S_LOOP  = ctrl_t'(1);
    localparam ctrl_t S_SCALE = ctrl_t'(2);
    localparam ctrl_t S_PACK  = ctrl_t'(3);

    ctrl_t                state, state_next;
    logic [ITER_BITS-1:0] iter;
    logic [63:0]          mant, mant_sq;
    logic [FRAC_BITS-1:0] frac_log;
    logic [10:0]          exp_in;
    logic                 special, in_special, in_nan, in_inf, in_zero;
    logic [63:0]          special_val, in_special_val;
    logic [FIX_BITS-1:0]  mag_ln, log2_fix, log2_mag;
    logic                 neg;
    logic [LEAD_BITS-1:0] lead;
    logic                 ready_next;
    logic [DATA_SIZE-1:0] data_out_next;

    // Classify the operand; subnormals are treated as zero
    always_comb begin
        in_nan     = (&DATA_IN[62:52]) && (|DATA_IN[51:0]);
        in_inf     = (&DATA_IN[62:52]) && !(|DATA_IN[51:0]);
        in_zero    = !(|DATA_IN[62:52]);
        in_special = in_nan || in_inf || in_zero || DATA_IN[63];
        if (in_nan)            in_special_val = QNAN;
        else if (in_zero)      in_special_val = NEG_INF;
        else if (DATA_IN[63])  in_special_val = QNAN;
        else if (in_inf)       in_special_val = POS_INF;
        else                   in_special_val = 64'h0;
    end

    // Mantissa squaring step and signed fixed-point log2 assembly
    always_comb begin
        mant_sq  = 64'((128'(mant) * 128'(mant)) >> 62);
        log2_fix = {12'(exp_in) - 12'd1023, frac_log};
        log2_mag = log2_fix[FIX_BITS-1] ? -log2_fix : log2_fix;
    end

    // Leading-one position of the |ln| magnitude for renormalisation
    always_comb begin
        lead = '0;
        for (int i = 0; i < int'(FIX_BITS); i++) begin
            if (mag_ln[i]) lead = LEAD_BITS'(i);
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; fixed iteration count keeps latency constant
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (START) state_next = S_LOOP;
            S_LOOP:  if (iter == ITER_BITS'(FRAC_BITS - 1)) state_next = S_SCALE;
            S_SCALE: state_next = S_PACK;
            S_PACK:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: pack sign/exponent/truncated mantissa into binary64
    always_comb begin
        ready_next    = 1'b0;
        data_out_next = DATA_OUT;
        if (state == S_PACK) begin
            ready_next = 1'b1;
            if (special)
                data_out_next = DATA_SIZE'(special_val);
            else if (mag_ln == '0)
                data_out_next = '0;
            else
                data_out_next = DATA_SIZE'({neg, 11'(lead) + 11'(EXP_OFFSET),
                    52'((mag_ln << (LEAD_BITS'(FIX_BITS - 1) - lead)) >> (FIX_BITS - 1 - 52))});
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            READY       <= 1'b0;
            DATA_OUT    <= '0;
            iter        <= '0;
            mant        <= '0;
            frac_log    <= '0;
            exp_in      <= '0;
            special     <= 1'b0;
            special_val <= '0;
            mag_ln      <= '0;
            neg         <= 1'b0;
        end else begin
            READY    <= ready_next;
            DATA_OUT <= data_out_next;
            case (state)
                S_IDLE: if (START) begin
                    mant        <= {2'b01, DATA_IN[51:0], 10'b0};
                    exp_in      <= DATA_IN[62:52];
                    frac_log    <= '0;
                    iter        <= '0;
                    special     <= in_special;
                    special_val <= in_special_val;
                end
                S_LOOP: begin
                    mant     <= mant_sq[63] ? (mant_sq >> 1) : mant_sq;
                    frac_log <= {frac_log[FRAC_BITS-2:0], mant_sq[63]};
                    iter     <= iter + ITER_BITS'(1);
                end
                S_SCALE: begin
                    mag_ln <= FIX_BITS'((136'(log2_mag) * 136'(LN2_Q64)) >> 64);
                    neg    <= log2_fix[FIX_BITS-1];
                end
                default: ;
            endcase
        end
    end
endmodule

module accelerator_vector_logarithm_function #(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] SIZE_IN,
    input  logic                 DATA_IN_ENABLE,
    output logic                 DATA_ENABLE,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 DATA_OUT_ENABLE
);
    typedef enum logic [1:0] {STARTER_STATE, INPUT_STATE, ENDER_STATE} state_t;

    state_t               state, state_next;
    logic [DATA_SIZE-1:0] index, index_next, size_latched, size_next;
    logic [DATA_SIZE-1:0] scalar_data_in, scalar_data_in_next, scalar_data_out, data_out_next;
    logic                 scalar_start, scalar_start_next, scalar_ready;
    logic                 ready_next, data_enable_next, data_out_enable_next, last_element;

    assign last_element = (index == size_latched - DATA_SIZE'(1));

    accelerator_scalar_logarithm_function #(
        .DATA_SIZE    (DATA_SIZE),
        .CONTROL_SIZE (CONTROL_SIZE)
    ) scalar_logarithm (
        .CLK      (CLK),
        .RST      (RST),
        .START    (scalar_start),
        .DATA_IN  (scalar_data_in),
        .READY    (scalar_ready),
        .DATA_OUT (scalar_data_out)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= STARTER_STATE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            STARTER_STATE: if (START && SIZE_IN != '0) state_next = INPUT_STATE;
            INPUT_STATE:   if (DATA_IN_ENABLE) state_next = ENDER_STATE;
            ENDER_STATE:   if (scalar_ready) state_next = last_element ? STARTER_STATE : INPUT_STATE;
            default:       state_next = STARTER_STATE;
        endcase
    end

    // Output logic: next values for the registered handshakes and data
    always_comb begin
        ready_next           = 1'b0;
        data_out_enable_next = 1'b0;
        scalar_start_next    = 1'b0;
        data_enable_next     = DATA_ENABLE;
        data_out_next        = DATA_OUT;
        index_next           = index;
        size_next            = size_latched;
        scalar_data_in_next  = scalar_data_in;
        case (state)
            STARTER_STATE: if (START) begin
                if (SIZE_IN == '0) begin
                    ready_next = 1'b1;
                end else begin
                    size_next        = SIZE_IN;
                    index_next       = '0;
                    data_enable_next = 1'b1;
                end
            end
            INPUT_STATE: if (DATA_IN_ENABLE) begin
                scalar_data_in_next = DATA_IN;
                scalar_start_next   = 1'b1;
                data_enable_next    = 1'b0;
            end
            ENDER_STATE: if (scalar_ready) begin
                data_out_next        = scalar_data_out;
                data_out_enable_next = 1'b1;
                if (last_element) begin
                    ready_next = 1'b1;
                    index_next = '0;
                end else begin
                    index_next       = index + DATA_SIZE'(1);
                    data_enable_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            READY           <= 1'b0;
            DATA_ENABLE     <= 1'b0;
            DATA_OUT_ENABLE <= 1'b0;
            DATA_OUT        <= '0;
            index           <= '0;
            size_latched    <= '0;
            scalar_start    <= 1'b0;
            scalar_data_in  <= '0;
        end else begin
            READY           <= ready_next;
            DATA_ENABLE     <= data_enable_next;
            DATA_OUT_ENABLE <= data_out_enable_next;
            DATA_OUT        <= data_out_next;
            index           <= index_next;
            size_latched    <= size_next;
            scalar_start    <= scalar_start_next;
            scalar_data_in  <= scalar_data_in_next;
        end
    end
endmodule
